// File: rtl/annunciator.sv
// annunciator: programmable tone speaker (off/continuous/pattern/burst) plus N blinking active-low LEDs.
// Ports: clk, reset (async active-high); spk_mode, tone_div, spk_pattern, burst_start, burst_len, mute,
// led_mode in; speaker, speaker_n, led_n, burst_busy, tick out.
// Optional ANNUNCIATOR_WARBLE_EN: during a burst the tone divisor alternates per tick between tone_div and tone_div>>1.
module annunciator #(
    parameter int TICK_DIV   = 4800000,
    parameter int N_LED      = 2,
    parameter int TONE_DIV_W = 16,
    parameter int PAT_LEN    = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              spk_mode,
    input  logic [TONE_DIV_W-1:0]   tone_div,
    input  logic [PAT_LEN-1:0]      spk_pattern,
    input  logic                    burst_start,
    input  logic [7:0]              burst_len,
    input  logic                    mute,
    input  logic [2*N_LED-1:0]      led_mode,
    output logic                    speaker,
    output logic                    speaker_n,
    output logic [N_LED-1:0]        led_n,
    output logic                    burst_busy,
    output logic                    tick
);
    localparam int TW = $clog2(TICK_DIV);
    localparam int PW = $clog2(PAT_LEN);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                  state, state_nxt;
    logic [7:0]              remaining;
    logic [TW-1:0]           tick_cnt;
    logic [TONE_DIV_W-1:0]   tone_cnt, div_q, eff_div;
    logic                    tone_sq, tone_wrap;
    logic [PW-1:0]           pat_idx;
    logic [1:0]              mode_q;
    logic [2:0]              blink_cnt;
    logic                    gate, spk_q, load, mode2_entry;
    logic [N_LED-1:0]        led_nxt;

    assign load        = (state == IDLE) && burst_start && (burst_len != 8'd0);
    assign mode2_entry = (spk_mode == 2'd2) && (mode_q != 2'd2);
    assign speaker     = spk_q;
    assign speaker_n   = ~spk_q;

`ifdef ANNUNCIATOR_WARBLE_EN
    logic warble;
    always_ff @(posedge clk or posedge reset)
        if (reset) warble <= 1'b0;
        else if (state == IDLE) warble <= 1'b0;
        else if (tick) warble <= ~warble;
    assign eff_div = (burst_busy && warble) ? (tone_div >> 1) : tone_div;
`else
    assign eff_div = tone_div;
`endif

    // A latched divisor of 0 means the generator is coming out of silence: load first, then count.
    assign tone_wrap = (div_q == '0) || (tone_cnt == div_q - 1'b1);

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            tone_cnt <= '0;
            div_q    <= '0;
            tone_sq  <= 1'b0;
        end else if (eff_div == '0) begin
            tone_cnt <= '0;
            div_q    <= '0;
            tone_sq  <= 1'b0;
        end else if (tone_wrap) begin
            tone_cnt <= '0;
            div_q    <= eff_div;
            tone_sq  <= tone_sq ^ (div_q != '0);
        end else begin
            tone_cnt <= tone_cnt + 1'b1;
        end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state     <= IDLE;
            remaining <= 8'd0;
        end else begin
            state     <= state_nxt;
            remaining <= load ? burst_len : (state == BURST && tick) ? remaining - 8'd1 : remaining;
        end

    always_comb begin
        state_nxt = state;
        state_nxt = (state == IDLE) ? (load ? BURST : IDLE) : ((tick && remaining == 8'd1) ? IDLE : BURST);
    end

    always_comb begin
        burst_busy = 1'b0;
        burst_busy = (state == BURST);
    end

    always_comb begin
        gate = 1'b0;
        gate = (spk_mode == 2'd0) ? 1'b0 :
               (spk_mode == 2'd1) ? 1'b1 :
               (spk_mode == 2'd2) ? spk_pattern[pat_idx] : burst_busy;
    end

    // Mode bits per channel: 00 off, 01 on, 10 slow (blink bit 2), 11 fast (blink bit 0).
    always_comb begin
        led_nxt = '1;
        for (int i = 0; i < N_LED; i++)
            led_nxt[i] = led_mode[2*i+1] ? ~blink_cnt[led_mode[2*i] ? 0 : 2] : ~led_mode[2*i];
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            tick_cnt  <= '0;
            tick      <= 1'b0;
            pat_idx   <= '0;
            mode_q    <= 2'd0;
            blink_cnt <= 3'd0;
            spk_q     <= 1'b0;
            led_n     <= '1;
        end else begin
            tick_cnt  <= (tick_cnt == TW'(TICK_DIV - 1)) ? '0 : tick_cnt + 1'b1;
            tick      <= (tick_cnt == TW'(TICK_DIV - 1));
            pat_idx   <= mode2_entry ? '0 : !tick ? pat_idx : (pat_idx == PW'(PAT_LEN - 1)) ? '0 : pat_idx + 1'b1;
            mode_q    <= spk_mode;
            blink_cnt <= tick ? blink_cnt + 3'd1 : blink_cnt;
            spk_q     <= tone_sq & gate & ~mute;
            led_n     <= led_nxt;
        end
endmodule

// File: tb/tb_annunciator.sv
// tb_annunciator: randomized stimulus against a cycle-level behavioural model of the annunciator.
module tb_annunciator;
    localparam int TD = 10;
    localparam int PL = 8;
    localparam int NL = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  spk_mode = 2'd0;
    logic [15:0] tone_div = 16'd0;
    logic [7:0]  spk_pattern = 8'd0;
    logic        burst_start = 1'b0;
    logic [7:0]  burst_len = 8'd0;
    logic        mute = 1'b0;
    logic [3:0]  led_mode = 4'd0;
    logic        speaker, speaker_n, burst_busy, tick;
    logic [1:0]  led_n;

    int n_tests = 0;
    int n_fail = 0;

    int cyc, pat, prev_mode, rem, blink, mdiv, mleft;
    bit msq, e_spk, e_tick;
    bit [1:0] e_led;

    annunciator #(.TICK_DIV(TD), .N_LED(NL), .TONE_DIV_W(16), .PAT_LEN(PL)) dut (
        .clk(clk), .reset(reset), .spk_mode(spk_mode), .tone_div(tone_div),
        .spk_pattern(spk_pattern), .burst_start(burst_start), .burst_len(burst_len),
        .mute(mute), .led_mode(led_mode), .speaker(speaker), .speaker_n(speaker_n),
        .led_n(led_n), .burst_busy(burst_busy), .tick(tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        cyc = 0; pat = 0; prev_mode = 0; rem = 0; blink = 0;
        mdiv = 0; mleft = 0; msq = 0; e_spk = 0; e_tick = 0; e_led = 2'b11;
    endtask

    // Advance the model across one rising edge using the inputs currently applied.
    task automatic model_edge();
        bit tick_now, gate;
        int m;
        tick_now = (cyc > 0) && (cyc % TD == 0);
        gate = (spk_mode == 0) ? 1'b0 : (spk_mode == 1) ? 1'b1 :
               (spk_mode == 2) ? spk_pattern[pat] : (rem != 0);
        e_spk = msq & gate & !mute;
        for (int i = 0; i < NL; i++) begin
            m = int'(led_mode[2*i +: 2]);
            e_led[i] = (m == 0) ? 1'b1 : (m == 1) ? 1'b0 : (m == 2) ? (blink < 4) : (blink % 2 == 0);
        end
        if (tone_div == 0) begin
            msq = 0; mdiv = 0;
        end else if (mdiv == 0) begin
            mdiv = int'(tone_div); mleft = int'(tone_div);
        end else begin
            mleft--;
            if (mleft == 0) begin
                msq = !msq; mdiv = int'(tone_div); mleft = int'(tone_div);
            end
        end
        if (spk_mode == 2 && prev_mode != 2) pat = 0;
        else if (tick_now) pat = (pat + 1) % PL;
        prev_mode = int'(spk_mode);
        if (rem == 0) begin
            if (burst_start && burst_len != 0) rem = int'(burst_len);
        end else if (tick_now) rem--;
        if (tick_now) blink = (blink + 1) % 8;
        cyc++;
        e_tick = (cyc % TD == 0);
    endtask

    task automatic check_outputs(input string pfx);
        check({pfx, "speaker"}, speaker, e_spk);
        check({pfx, "speaker_n"}, speaker_n, !e_spk);
        check({pfx, "led_n"}, led_n, e_led);
        check({pfx, "burst_busy"}, burst_busy, rem != 0);
        check({pfx, "tick"}, tick, e_tick);
    endtask

    task automatic step();
        model_edge();
        @(negedge clk);
        check_outputs("");
    endtask

    task automatic run_segment(input int len);
        int opts[7] = '{0, 1, 2, 3, 4, 5, 8};
        spk_mode    = 2'($urandom_range(0, 3));
        tone_div    = 16'(opts[$urandom_range(0, 6)]);
        spk_pattern = 8'($urandom);
        burst_len   = 8'($urandom_range(0, 4));
        mute        = ($urandom % 4 == 0);
        led_mode    = 4'($urandom);
        for (int k = 0; k < len; k++) begin
            burst_start = ($urandom % 30 == 0);
            if ($urandom % 60 == 0) led_mode = 4'($urandom);
            if ($urandom % 80 == 0) tone_div = 16'(opts[$urandom_range(0, 6)]);
            step();
        end
        burst_start = 1'b0;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        check_outputs("reset_");
        reset = 1'b0;
        spk_mode = 2'd1; tone_div = 16'd4; led_mode = 4'b1110;
        for (int k = 0; k < 100; k++) step();
        spk_mode = 2'd0; tone_div = 16'd2; spk_pattern = 8'b0000_0101;
        for (int k = 0; k < 5; k++) step();
        spk_mode = 2'd2;
        for (int k = 0; k < 170; k++) step();
        spk_mode = 2'd3; burst_len = 8'd3; burst_start = 1'b1;
        step();
        burst_start = 1'b0;
        for (int k = 0; k < 12; k++) step();
        burst_start = 1'b1; burst_len = 8'd4;
        step();
        burst_start = 1'b0;
        for (int k = 0; k < 40; k++) step();
        burst_len = 8'd0; burst_start = 1'b1;
        step();
        burst_start = 1'b0;
        for (int k = 0; k < 20; k++) step();
        for (int s = 0; s < 40; s++) run_segment($urandom_range(40, 200));

        spk_mode = 2'd3; tone_div = 16'd2; mute = 1'b0; burst_len = 8'd4; led_mode = 4'b0101;
        for (int k = 0; k < 60; k++) step();
        burst_start = 1'b1;
        step();
        burst_start = 1'b0;
        for (int k = 0; k < 100 && rem != 2; k++) step();
        check("burst_reach_rem2", rem, 2);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_outputs("async_rst_");
        @(negedge clk);
        reset = 1'b0;
        check_outputs("post_rst_");
        for (int s = 0; s < 8; s++) run_segment($urandom_range(40, 150));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/annunciator.md
Name: annunciator

Overview:
Parametrised speaker/LED annunciator. Successor to the fixed count-bit speaker tap and hard-wired LED drives in the chip top.
- Generates a programmable square-wave tone, gated by one of four speaker modes: off, continuous, repeating bit pattern, one-shot timed burst.
- Drives N active-low LEDs, each independently off, on, slow blink or fast blink.
- Sits in the 48 MHz clk domain beside the blaster controller; outputs go straight to pads.

Parameters:
TICK_DIV, 4800000, clk cycles per timebase tick (100 ms at 48 MHz); must be >= 2
N_LED, 2, number of LED channels
TONE_DIV_W, 16, width of tone half-period divisor
PAT_LEN, 8, speaker pattern length in ticks; must be >= 2

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
spk_mode  in  2  0 off, 1 continuous, 2 pattern, 3 burst
tone_div  in  TONE_DIV_W  tone half-period in clk cycles; 0 = silence
spk_pattern  in  PAT_LEN  one bit per tick, LSB first, 1 = sound
burst_start  in  1  one-cycle pulse, starts a burst
burst_len  in  8  burst length in ticks
mute  in  1  forces speaker silent; timing keeps running
led_mode  in  2*N_LED  2 bits per channel, channel i at [2i+1:2i]: 0 off, 1 on, 2 slow, 3 fast
speaker  out  1  tone output
speaker_n  out  1  complement of speaker (differential drive)
led_n  out  N_LED  active-low LED drives
burst_busy  out  1  high while a burst is active
tick  out  1  one-cycle pulse per timebase tick

Behaviour:
- Reset values, asynchronous: speaker=0, speaker_n=1, led_n=all 1, burst_busy=0, tick=0; all counters, indices and state =0.
- Timebase:
  - tick_cnt counts 0..TICK_DIV-1, then wraps to 0.
  - tick is asserted in the cycle after tick_cnt==TICK_DIV-1.
  - First tick after reset release occurs in cycle TICK_DIV.
- Tone generator:
  - tone_cnt counts 0..tone_div-1; at terminal count it wraps and toggles tone_sq.
  - tone_div is sampled only at wrap, so a new value takes effect at the next half-period boundary.
  - tone_div==0: tone_cnt and tone_sq held at 0.
  - Runs regardless of gating.
- Pattern index:
  - pat_idx advances on tick and wraps PAT_LEN-1 -> 0.
  - Forced to 0 in the cycle after spk_mode transitions into 2. Mode is registered internally to detect the transition.
- Burst FSM, states IDLE and BURST:
  - IDLE -> BURST when burst_start=1 and burst_len!=0: loads remaining=burst_len; burst_busy=1 from the next cycle.
  - In BURST, remaining decrements on each tick. When a tick arrives with remaining==1, go to IDLE and burst_busy=0 the next cycle.
  - burst_start while in BURST is ignored (no retrigger). burst_len==0 is ignored.
  - The FSM runs in every spk_mode. Leaving mode 3 does not abort a burst.
- Gate:
  - Mode 0: 0. Mode 1: 1. Mode 2: spk_pattern[pat_idx]. Mode 3: burst_busy.
- Speaker output:
  - speaker and speaker_n come from one register fed by tone_sq & gate & !mute; speaker_n is always the exact complement.
  - Latency from gate or mute change to pin: 1 clk.
- LEDs:
  - A 3-bit blink_cnt increments on tick.
  - Per channel: off -> 1; on -> 0; slow -> !blink_cnt[2] (4 ticks on / 4 off); fast -> !blink_cnt[0] (1 on / 1 off).
  - led_n is registered, 1 clk latency.
- Simultaneous events:
  - tick coinciding with burst_start in IDLE: load takes priority; that tick does not decrement.
  - tick coinciding with a mode-2 entry: pat_idx goes to 0, not 1.
- A reset assertion mid-burst or mid-tone returns immediately to reset values.

Optional Feature:
ANNUNCIATOR_WARBLE_EN
- Defined: while burst_busy=1, the effective tone divisor alternates each tick between tone_div and tone_div>>1, giving a two-tone warble. It starts with tone_div at burst entry. tone_div>>1==0 means silence during that tick.
- Undefined: effective divisor is always tone_div. No extra flops.

Test Plan:
All scenarios use TICK_DIV=10, PAT_LEN=8, N_LED=2.
- Reset/idle: release reset, spk_mode=1, tone_div=4, mute=0 -> speaker toggles every 4 clk (period 8), speaker_n==~speaker every cycle; tick every 10 clk, first at cycle 10.
- Pattern: spk_mode 0->2, spk_pattern=8'b0000_0101, tone_div=2 -> speaker active during ticks 0 and 2 of each 8-tick cycle, silent otherwise; pattern restarts at index 0 on re-entry.
- Burst: spk_mode=3, burst_start pulse with burst_len=3 -> burst_busy high for exactly 3 ticks; second burst_start mid-burst has no effect; burst_len=0 pulse leaves burst_busy=0.
- LEDs: led_mode=4'b11_10 -> led_n[0] low 40 clk / high 40 clk; led_n[1] low 10 / high 10; changing ch0 to mode 1 -> led_n[0]=0 within 1 clk.
- Mute and zero divisor: continuous mode with mute=1 -> speaker=0, speaker_n=1; tone_div=0 -> speaker constant 0.
- Async reset mid-burst: assert reset with remaining=2 -> burst_busy, speaker, tick 0, led_n=2'b11 immediately, before the next clk edge.
